counter_sequencer: RTL and testbench

Autonomous program sequencer for the step-counter datapath. It runs the three counting programs in a fixed order, each on one shared internal count register: L (step 1), E (step 4), U (step 10). Each program counts from 0 up to LIMIT at a prescaled tick rate. The block adds pause, skip and loop control, and drives the program-letter display and status LEDs. Its count output feeds the existing BCD/7-segment digit path.

---
 rtl/counter_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_counter_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Runs the L/E/U counting programs back to back on one shared count register,
// with synchronized start/pause/skip buttons and optional looping after U.
module counter_sequencer #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int LIMIT     = 999,
    parameter int GAP_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_button,
    input  logic       pause_button,
    input  logic       skip_button,
    input  logic       mode_loop,
    output logic [6:0] display_7seg,
    output logic [9:0] count,
    output logic [3:0] step,
    output logic       busy,
    output logic       done,
    output logic [4:0] led
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [PW-1:0] PS_MAX  = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_TICKS - 1);
    localparam logic [9:0]    LIM     = 10'(LIMIT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_PAUSE = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] P_L = 2'd0;
    localparam logic [1:0] P_E = 2'd1;
    localparam logic [1:0] P_U = 2'd2;

    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    prev;
    logic [2:0]    evt;
    logic          start_evt;
    logic          pause_evt;
    logic          skip_evt;
    logic [2:0]    state;
    logic [2:0]    resume;
    logic [1:0]    prog;
    logic [PW-1:0] prescaler;
    logic [PW-1:0] ps_next;
    logic [GW-1:0] gap_cnt;
    logic          tick;
    logic [10:0]   sum;

    // Button synchronizers and edge-detect history, bits {skip, pause, start}.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
            prev  <= 3'b000;
        end else begin
            sync1 <= {skip_button, pause_button, start_button};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign evt       = sync2 & ~prev;
    assign start_evt = evt[0];
    assign pause_evt = evt[1];
    assign skip_evt  = evt[2];

    assign tick    = (prescaler == PS_MAX);
    assign ps_next = tick ? '0 : prescaler + PW'(1);
    assign sum     = {1'b0, count} + {7'b0000000, step};

    // Sequencer FSM with prescaler, count and gap counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            resume    <= S_RUN;
            prog      <= P_L;
            count     <= 10'd0;
            prescaler <= '0;
            gap_cnt   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_evt) begin
                        state     <= S_RUN;
                        prog      <= P_L;
                        count     <= 10'd0;
                        prescaler <= '0;
                    end
                end
                S_RUN: begin
                    if (skip_evt) begin
                        state     <= S_GAP;
                        prescaler <= '0;
                        gap_cnt   <= '0;
                    end else if (pause_evt) begin
                        // A pause that lands on a tick edge holds the tick for after resume.
                        state  <= S_PAUSE;
                        resume <= S_RUN;
                        if (!tick) begin
                            prescaler <= prescaler + PW'(1);
                        end
                    end else begin
                        prescaler <= ps_next;
                        if (tick) begin
                            if (sum >= {1'b0, LIM}) begin
                                count     <= LIM;
                                state     <= S_GAP;
                                prescaler <= '0;
                                gap_cnt   <= '0;
                            end else begin
                                count <= sum[9:0];
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (skip_evt) begin
                        state     <= S_GAP;
                        prescaler <= '0;
                        gap_cnt   <= '0;
                    end else if (pause_evt) begin
                        state <= resume;
                    end
                end
                S_GAP: begin
                    if (pause_evt) begin
                        state  <= S_PAUSE;
                        resume <= S_GAP;
                        if (!tick) begin
                            prescaler <= prescaler + PW'(1);
                        end
                    end else begin
                        prescaler <= ps_next;
                        if (tick) begin
                            if (gap_cnt == GAP_MAX) begin
                                gap_cnt <= '0;
                                case (prog)
                                    P_L: begin
                                        prog  <= P_E;
                                        count <= 10'd0;
                                        state <= S_RUN;
                                    end
                                    P_E: begin
                                        prog  <= P_U;
                                        count <= 10'd0;
                                        state <= S_RUN;
                                    end
                                    default: begin
                                        if (mode_loop) begin
                                            prog  <= P_L;
                                            count <= 10'd0;
                                            state <= S_RUN;
                                        end else begin
                                            count <= LIM;
                                            state <= S_DONE;
                                            done  <= 1'b1;
                                        end
                                    end
                                endcase
                            end else begin
                                gap_cnt <= gap_cnt + GW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Letter, step and program LEDs decoded from the active program.
    always_comb begin
        display_7seg = 7'b1000111;
        step         = 4'd1;
        led[2:0]     = 3'b001;
        case (prog)
            P_L: begin
                display_7seg = 7'b1000111;
                step         = 4'd1;
                led[2:0]     = 3'b001;
            end
            P_E: begin
                display_7seg = 7'b0000110;
                step         = 4'd4;
                led[2:0]     = 3'b010;
            end
            P_U: begin
                display_7seg = 7'b1000001;
                step         = 4'd10;
                led[2:0]     = 3'b100;
            end
            default: begin
                display_7seg = 7'b1000111;
                step         = 4'd1;
                led[2:0]     = 3'b001;
            end
        endcase
    end

    assign busy   = (state == S_RUN) || (state == S_PAUSE) || (state == S_GAP);
    assign led[3] = (state == S_PAUSE);
    assign led[4] = (state == S_DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with TICK_DIV=4, LIMIT=12, GAP_TICKS=1.
module tb_counter_sequencer;

    localparam int TD = 4;
    localparam int LM = 12;
    localparam int GT = 1;

    localparam logic [6:0] DL = 7'b1000111;
    localparam logic [6:0] DE = 7'b0000110;
    localparam logic [6:0] DU = 7'b1000001;

    typedef struct {
        int         cyc;
        logic [9:0] cnt;
        logic [3:0] stp;
        logic [6:0] disp;
        logic [4:0] led;
        logic       busy;
        logic       done;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_button;
    logic       pause_button;
    logic       skip_button;
    logic       mode_loop;
    logic [6:0] display_7seg;
    logic [9:0] count;
    logic [3:0] step;
    logic       busy;
    logic       done;
    logic [4:0] led;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    vec_t tbl [18];

    counter_sequencer #(.TICK_DIV(TD), .LIMIT(LM), .GAP_TICKS(GT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_button (start_button),
        .pause_button (pause_button),
        .skip_button  (skip_button),
        .mode_loop    (mode_loop),
        .display_7seg (display_7seg),
        .count        (count),
        .step         (step),
        .busy         (busy),
        .done         (done),
        .led          (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input vec_t v, input string tag);
        chk({tag, ".count"}, 32'(count), 32'(v.cnt));
        chk({tag, ".step"}, 32'(step), 32'(v.stp));
        chk({tag, ".disp"}, 32'(display_7seg), 32'(v.disp));
        chk({tag, ".led"}, 32'(led), 32'(v.led));
        chk({tag, ".busy"}, 32'(busy), 32'(v.busy));
        chk({tag, ".done"}, 32'(done), 32'(v.done));
    endtask

    // Drive {skip,pause,start}; returns 1ns after the edge that acts on it.
    task automatic press(input logic [2:0] m);
        @(negedge clk);
        start_button = m[0];
        pause_button = m[1];
        skip_button  = m[2];
        repeat (3) @(posedge clk);
        #1;
        start_button = 1'b0;
        pause_button = 1'b0;
        skip_button  = 1'b0;
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
        cyc += n;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{0,  10'd0,  4'd1,  DL, 5'b00001, 1'b1, 1'b0};
        tbl[1]  = '{3,  10'd0,  4'd1,  DL, 5'b00001, 1'b1, 1'b0};
        tbl[2]  = '{4,  10'd1,  4'd1,  DL, 5'b00001, 1'b1, 1'b0};
        tbl[3]  = '{8,  10'd2,  4'd1,  DL, 5'b00001, 1'b1, 1'b0};
        tbl[4]  = '{47, 10'd11, 4'd1,  DL, 5'b00001, 1'b1, 1'b0};
        tbl[5]  = '{48, 10'd12, 4'd1,  DL, 5'b00001, 1'b1, 1'b0};
        tbl[6]  = '{51, 10'd12, 4'd1,  DL, 5'b00001, 1'b1, 1'b0};
        tbl[7]  = '{52, 10'd0,  4'd4,  DE, 5'b00010, 1'b1, 1'b0};
        tbl[8]  = '{56, 10'd4,  4'd4,  DE, 5'b00010, 1'b1, 1'b0};
        tbl[9]  = '{64, 10'd12, 4'd4,  DE, 5'b00010, 1'b1, 1'b0};
        tbl[10] = '{67, 10'd12, 4'd4,  DE, 5'b00010, 1'b1, 1'b0};
        tbl[11] = '{68, 10'd0,  4'd10, DU, 5'b00100, 1'b1, 1'b0};
        tbl[12] = '{72, 10'd10, 4'd10, DU, 5'b00100, 1'b1, 1'b0};
        tbl[13] = '{76, 10'd12, 4'd10, DU, 5'b00100, 1'b1, 1'b0};
        tbl[14] = '{79, 10'd12, 4'd10, DU, 5'b00100, 1'b1, 1'b0};
        tbl[15] = '{80, 10'd12, 4'd10, DU, 5'b10100, 1'b0, 1'b1};
        tbl[16] = '{81, 10'd12, 4'd10, DU, 5'b10100, 1'b0, 1'b0};
        tbl[17] = '{90, 10'd12, 4'd10, DU, 5'b10100, 1'b0, 1'b0};

        reset        = 1'b0;
        start_button = 1'b0;
        pause_button = 1'b0;
        skip_button  = 1'b0;
        mode_loop    = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk_vec('{0, 10'd0, 4'd1, DL, 5'b00001, 1'b0, 1'b0}, "reset");
        @(negedge clk);
        reset = 1'b0;
        adv(3);
        chk("idle.busy", 32'(busy), 32'd0);

        // Full L/E/U sequence to DONE, checked against the table.
        press(3'b001);
        cyc = 0;
        for (int i = 0; i < 18; i++) begin
            adv(tbl[i].cyc - cyc);
            chk_vec(tbl[i], $sformatf("seq[%0d]", i));
        end

        // Pause at count 5 acted one edge after the tick, resume keeps phase.
        do_reset();
        press(3'b001);
        adv(18);
        press(3'b010);
        chk("pause.count", 32'(count), 32'd5);
        chk("pause.led", 32'(led), 32'b01001);
        adv(100);
        chk("pause_hold.count", 32'(count), 32'd5);
        chk("pause_hold.led", 32'(led), 32'b01001);
        chk("pause_hold.busy", 32'(busy), 32'd1);
        press(3'b010);
        chk("resume.led", 32'(led), 32'b00001);
        adv(2);
        chk("resume+2.count", 32'(count), 32'd5);
        adv(1);
        chk("resume+3.count", 32'(count), 32'd6);

        // Skip at count 5: hold 5 through one gap tick, then program E.
        do_reset();
        press(3'b001);
        adv(18);
        press(3'b100);
        chk("skip.count", 32'(count), 32'd5);
        chk("skip.busy", 32'(busy), 32'd1);
        adv(3);
        chk("skip_gap.count", 32'(count), 32'd5);
        chk("skip_gap.step", 32'(step), 32'd1);
        adv(1);
        chk_vec('{0, 10'd0, 4'd4, DE, 5'b00010, 1'b1, 1'b0}, "skip_e");

        // Loop mode: after U, back to L with no done pulse.
        do_reset();
        mode_loop = 1'b1;
        press(3'b001);
        adv(79);
        chk("loop79.count", 32'(count), 32'd12);
        chk("loop79.step", 32'(step), 32'd10);
        adv(1);
        chk_vec('{0, 10'd0, 4'd1, DL, 5'b00001, 1'b1, 1'b0}, "loop80");
        adv(1);
        chk("loop81.done", 32'(done), 32'd0);
        chk("loop81.busy", 32'(busy), 32'd1);
        adv(3);
        chk("loop84.count", 32'(count), 32'd1);
        mode_loop = 1'b0;

        // Skip and pause together on a tick edge: GAP wins, no increment.
        do_reset();
        press(3'b001);
        adv(21);
        press(3'b110);
        chk("both.count", 32'(count), 32'd5);
        chk("both.led", 32'(led), 32'b00001);
        chk("both.busy", 32'(busy), 32'd1);
        adv(3);
        chk("both+3.count", 32'(count), 32'd5);
        adv(1);
        chk("both+4.step", 32'(step), 32'd4);
        chk("both+4.count", 32'(count), 32'd0);

        // Asynchronous reset in program E at count 8.
        do_reset();
        press(3'b001);
        adv(61);
        chk("pre_rst.count", 32'(count), 32'd8);
        chk("pre_rst.step", 32'(step), 32'd4);
        #2 reset = 1'b1;
        #1;
        chk_vec('{0, 10'd0, 4'd1, DL, 5'b00001, 1'b0, 1'b0}, "async_rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        press(3'b010);
        adv(5);
        chk("post_rst_pause.led", 32'(led), 32'b00001);
        chk("post_rst_pause.busy", 32'(busy), 32'd0);
        press(3'b100);
        adv(5);
        chk("post_rst_skip.busy", 32'(busy), 32'd0);
        chk("post_rst_skip.count", 32'(count), 32'd0);
        press(3'b001);
        chk("restart.busy", 32'(busy), 32'd1);
        adv(4);
        chk("restart.count", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
